// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package sseg_scan_ctrl_pkg;

   typedef enum logic {
      ST_GAP   = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   localparam int         NDIG   = 4;
   localparam logic [3:0] AN_OFF = 4'b1111;

   // Active-low one-hot-cold anode pattern for the selected digit.
   function automatic logic [3:0] an_select(input logic [1:0] digit);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << digit);
   endfunction

endpackage

// File: rtl/sseg_hex_dec.sv
// Hex nibble to 7-segment decoder, segments gfedcba, active-high.
module sseg_hex_dec (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b0000000;
      case (hex)
         4'h0: seg = 7'b0111111;
         4'h1: seg = 7'b0000110;
         4'h2: seg = 7'b1011011;
         4'h3: seg = 7'b1001111;
         4'h4: seg = 7'b1100110;
         4'h5: seg = 7'b1101101;
         4'h6: seg = 7'b1111101;
         4'h7: seg = 7'b0000111;
         4'h8: seg = 7'b1111111;
         4'h9: seg = 7'b1101111;
         4'hA: seg = 7'b1110111;
         4'hB: seg = 7'b1111100;
         4'hC: seg = 7'b0111001;
         4'hD: seg = 7'b1011110;
         4'hE: seg = 7'b1111001;
         4'hF: seg = 7'b1110001;
         default: seg = 7'b0000000;
      endcase
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode display: per-digit dead time, then drive,
// with host updates held in a shadow copy until the frame boundary.
module sseg_scan_ctrl
   import sseg_scan_ctrl_pkg::*;
#(
   parameter int DIV = 50000,
   parameter int GAP = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_mask,
   output logic        load_ready,
   output logic [3:0]  an,
   output logic [6:0]  sseg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0]  GAP_LAST = CW'(GAP - 1);

   scan_state_t   state;
   logic [CW-1:0] cnt;
   logic [1:0]    digit;
   logic [15:0]   val_reg;
   logic [3:0]    dp_reg;
   logic [3:0]    blank_reg;
   logic [15:0]   shadow_val;
   logic [3:0]    shadow_dp;
   logic [3:0]    shadow_blank;
   logic          pend;
   logic [3:0]    nibble;
   logic [6:0]    seg;

   assign nibble     = val_reg[{digit, 2'b00} +: 4];
   assign load_ready = ~pend;

   sseg_hex_dec u_dec (
      .hex (nibble),
      .seg (seg)
   );

   // Outputs are loaded with the values of the state being entered, so they
   // change on the same edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_GAP;
         cnt          <= '0;
         digit        <= 2'd0;
         val_reg      <= 16'h0000;
         dp_reg       <= 4'h0;
         blank_reg    <= 4'h0;
         shadow_val   <= 16'h0000;
         shadow_dp    <= 4'h0;
         shadow_blank <= 4'h0;
         pend         <= 1'b0;
         an           <= AN_OFF;
         sseg         <= 7'b0000000;
         dp           <= 1'b0;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= 1'b0;

         if (load && !pend) begin
            shadow_val   <= value;
            shadow_dp    <= dp_in;
            shadow_blank <= blank_mask;
            pend         <= 1'b1;
         end

         case (state)
            ST_GAP: begin
               cnt <= cnt + 1'b1;
               if (cnt == GAP_LAST) begin
                  state <= ST_DRIVE;
                  if (blank_reg[digit]) begin
                     an   <= AN_OFF;
                     sseg <= 7'b0000000;
                     dp   <= 1'b0;
                  end else begin
                     an   <= an_select(digit);
                     sseg <= seg;
                     dp   <= dp_reg[digit];
                  end
               end
            end
            ST_DRIVE: begin
               if (cnt == CNT_LAST) begin
                  state <= ST_GAP;
                  cnt   <= '0;
                  digit <= digit + 2'd1;
                  an    <= AN_OFF;
                  sseg  <= 7'b0000000;
                  dp    <= 1'b0;
                  // Last digit of the frame: the only point where the display may change.
                  if (digit == 2'd3) begin
                     frame_tick <= 1'b1;
                     if (pend) begin
                        val_reg   <= shadow_val;
                        dp_reg    <= shadow_dp;
                        blank_reg <= shadow_blank;
                        pend      <= 1'b0;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_GAP;
         endcase
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: frames of expected digit drives are queued by the
// stimulus and consumed by a negedge monitor as the DUT lights each anode.
module tb_sseg_scan_ctrl;

   localparam int DIV = 8;
   localparam int GAP = 2;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  blank_mask;
   logic        load_ready;
   logic [3:0]  an;
   logic [6:0]  sseg;
   logic        dp;
   logic        frame_tick;

   sseg_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .blank_mask (blank_mask),
      .load_ready (load_ready),
      .an         (an),
      .sseg       (sseg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] an;
      logic [6:0] sseg;
      logic       dp;
      int         gap;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference of what the display should hold, independent of the DUT's counters.
   logic [15:0] m_val, s_val;
   logic [3:0]  m_dp, s_dp, m_blank, s_blank;
   logic        m_pend;
   int          blank_carry;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Queue one frame of expected drives; blanked slots lengthen the dark time before the next lit digit.
   task automatic expectFrame();
      exp_t       e;
      logic [3:0] one;
      one = 4'b0001;
      for (int d = 0; d < 4; d++) begin
         if (m_blank[d]) begin
            blank_carry++;
         end else begin
            e.an   = ~(one << d);
            e.sseg = seg_tbl[m_val[4*d +: 4]];
            e.dp   = m_dp[d];
            e.gap  = GAP + DIV * blank_carry;
            sb_q.push_back(e);
            blank_carry = 0;
         end
      end
   endtask

   task automatic onFrame();
      if (m_pend) begin
         m_val   = s_val;
         m_dp    = s_dp;
         m_blank = s_blank;
         m_pend  = 1'b0;
      end
      checkOutput("load_ready_after_tick", {31'd0, load_ready}, 32'd1);
      expectFrame();
   endtask

   task automatic waitFrameTick();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!frame_tick && n < 100);
      checkOutput("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
      onFrame();
   endtask

   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
      value      = v;
      dp_in      = dpv;
      blank_mask = bl;
      load       = 1'b1;
      checkOutput("load_ready_pre", {31'd0, load_ready}, {31'd0, !m_pend});
      if (!m_pend) begin
         s_val   = v;
         s_dp    = dpv;
         s_blank = bl;
         m_pend  = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      checkOutput("load_ready_post", {31'd0, load_ready}, 32'd0);
   endtask

   // Monitor: pops an expectation at the start of every lit drive and checks framing timing.
   int         gap_cnt = 0;
   int         burst = 0;
   int         since_tick = 0;
   logic       in_drive = 1'b0;
   logic       tick_seen = 1'b0;
   logic [11:0] held;

   always @(negedge clk) begin
      if (rst) begin
         in_drive   = 1'b0;
         gap_cnt    = 0;
         burst      = 0;
         tick_seen  = 1'b0;
         since_tick = 0;
      end else begin
         since_tick++;
         if (frame_tick) begin
            if (tick_seen) checkOutput("frame_period", since_tick, 4 * DIV);
            tick_seen  = 1'b1;
            since_tick = 0;
         end
         if (an == 4'b1111) begin
            if (in_drive) begin
               checkOutput("drive_len", burst, DIV - GAP);
               in_drive = 1'b0;
               gap_cnt  = 0;
            end
            gap_cnt++;
            checkOutput("dark_seg_dp", {24'd0, sseg, dp}, 32'd0);
         end else if (!in_drive) begin
            exp_t e;
            in_drive = 1'b1;
            burst    = 1;
            held     = {an, sseg, dp};
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL drive_unexpected: actual an=%b required no drive", an);
            end else begin
               e = sb_q.pop_front();
               checkOutput("drive_an", {28'd0, an}, {28'd0, e.an});
               checkOutput("drive_sseg", {25'd0, sseg}, {25'd0, e.sseg});
               checkOutput("drive_dp", {31'd0, dp}, {31'd0, e.dp});
               checkOutput("drive_gap", gap_cnt, e.gap);
            end
         end else begin
            burst++;
            checkOutput("drive_stable", {20'd0, an, sseg, dp}, {20'd0, held});
         end
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_mask = 4'h0;
      m_val = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_pend = 1'b0; blank_carry = 0;
      s_val = 16'h0; s_dp = 4'h0; s_blank = 4'h0;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_an", {28'd0, an}, 32'hF);
      checkOutput("reset_sseg_dp", {24'd0, sseg, dp}, 32'd0);
      checkOutput("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
      checkOutput("reset_load_ready", {31'd0, load_ready}, 32'd1);
      expectFrame();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("first_drive_an", {28'd0, an}, 32'hE);
      checkOutput("first_drive_sseg", {25'd0, sseg}, 32'h3F);
      waitFrameTick();

      // Simple load, pending until the frame boundary
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'h1A3F, 4'b0100, 4'b0000);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("load_ready_pending", {31'd0, load_ready}, 32'd0);
      waitFrameTick();

      // Back-to-back loads: the second is dropped
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'h1111, 4'b0000, 4'b0000);
      applyStimulus(16'h2222, 4'b0000, 4'b0000);
      waitFrameTick();
      waitFrameTick();

      // Blanked digits 1 and 3
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'h8888, 4'b0000, 4'b1010);
      waitFrameTick();
      waitFrameTick();

      // Load during the commit cycle is refused, accepted one cycle later
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'hCDE2, 4'b0001, 4'b0000);
      repeat (27) @(posedge clk);
      #1;
      value = 16'h4567; dp_in = 4'b1000; blank_mask = 4'b0000; load = 1'b1;
      checkOutput("load_ready_commit_cycle", {31'd0, load_ready}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("commit_tick", {31'd0, frame_tick}, 32'd1);
      onFrame();
      s_val = 16'h4567; s_dp = 4'b1000; s_blank = 4'b0000; m_pend = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      checkOutput("load_after_commit_taken", {31'd0, load_ready}, 32'd0);
      waitFrameTick();

      // Reset mid-drive of digit 2 with an update pending
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'hFFFF, 4'b1111, 4'b0000);
      repeat (16) @(posedge clk);
      #1;
      checkOutput("pre_reset_digit2", {28'd0, an}, 32'hB);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_an", {28'd0, an}, 32'hF);
      checkOutput("midreset_sseg_dp", {24'd0, sseg, dp}, 32'd0);
      checkOutput("midreset_frame_tick", {31'd0, frame_tick}, 32'd0);
      checkOutput("midreset_load_ready", {31'd0, load_ready}, 32'd1);
      sb_q.delete();
      m_val = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_pend = 1'b0; blank_carry = 0;
      expectFrame();
      rst = 1'b0;
      waitFrameTick();
      repeat (30) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
